// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
//
// Frame controller for an ADC -> sample buffer -> FFT -> Avalon writeback
// pipeline. It captures N_SAMPLES samples into the buffer, kicks the FFT,
// waits for it, kicks the writeback master, waits for it, counts the frame and
// loops while enable stays high. Both waits are bounded by TIMEOUT cycles.
//
// Parameters
//   N_SAMPLES    samples per frame (power of two, at most 512)
//   TIMEOUT      maximum cycles spent in WAIT_FFT or WAIT_UNLOAD
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   enable       run frames continuously while high
//   sample_valid one ADC sample present this cycle
//   cap_we       sample buffer write enable (CAPTURE only)
//   cap_addr     sample buffer write address
//   fft_start    one-cycle FFT start pulse
//   fft_done     FFT complete
//   unload_start one-cycle writeback start pulse
//   unload_done  writeback of the frame complete
//   unload_err   writeback saw a non-OKAY response
//   clear_err    clears err_code (leaving ERROR) and the overrun flag
//   busy         state is neither IDLE nor ERROR
//   frame_cnt    completed frames, wraps 255 -> 0
//   err_code     00 none, 01 FFT timeout, 10 unload error, 11 unload timeout
//   overrun      sticky: a sample arrived while no capture was possible
// -----------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int N_SAMPLES = 512,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       sample_valid,
    output logic       cap_we,
    output logic [8:0] cap_addr,
    output logic       fft_start,
    input  logic       fft_done,
    output logic       unload_start,
    input  logic       unload_done,
    input  logic       unload_err,
    input  logic       clear_err,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic [1:0] err_code,
    output logic       overrun
);

    localparam int              TW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [8:0]      LAST_SAMPLE = 9'(N_SAMPLES - 1);
    localparam logic [TW-1:0]   LAST_TICK   = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_FFT_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_UNLOAD      = 2'b10;
    localparam logic [1:0] ERR_UNLOAD_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START_FFT,
        S_WAIT_FFT,
        S_START_UNLOAD,
        S_WAIT_UNLOAD,
        S_ERROR
    } state_t;

    state_t          r_state,      w_state_next;
    logic [8:0]      r_sample_cnt, w_sample_cnt_next;
    logic [TW-1:0]   r_timer,      w_timer_next;
    logic [7:0]      r_frame_cnt,  w_frame_cnt_next;
    logic [1:0]      r_err_code,   w_err_code_next;
    logic            r_overrun,    w_overrun_next;
    logic            w_timer_expired;
    logic            w_in_processing;

    // The timer counts from 0 on the first wait cycle, so a wait state lasts
    // at most TIMEOUT cycles before giving up.
    assign w_timer_expired = (r_timer == LAST_TICK);

    // States in which the buffer is owned by the FFT/writeback path.
    assign w_in_processing = (r_state == S_START_FFT)    || (r_state == S_WAIT_FFT) ||
                             (r_state == S_START_UNLOAD) || (r_state == S_WAIT_UNLOAD);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_timer      <= '0;
            r_frame_cnt  <= '0;
            r_err_code   <= ERR_NONE;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_timer      <= w_timer_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_err_code   <= w_err_code_next;
            r_overrun    <= w_overrun_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next      = r_state;
        w_sample_cnt_next = r_sample_cnt;
        w_timer_next      = r_timer;
        w_frame_cnt_next  = r_frame_cnt;
        w_err_code_next   = r_err_code;
        cap_we            = 1'b0;
        fft_start         = 1'b0;
        unload_start      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next      = S_CAPTURE;
                    w_sample_cnt_next = '0;
                end
            end

            S_CAPTURE: begin
                cap_we = sample_valid;
                if (!enable) begin
                    // Abort: the partial frame is simply forgotten.
                    w_state_next      = S_IDLE;
                    w_sample_cnt_next = '0;
                end else if (sample_valid) begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        w_sample_cnt_next = '0;
                        w_state_next      = S_START_FFT;
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 9'd1;
                    end
                end
            end

            S_START_FFT: begin
                fft_start    = 1'b1;
                w_timer_next = '0;
                w_state_next = S_WAIT_FFT;
            end

            S_WAIT_FFT: begin
                w_timer_next = r_timer + 1'b1;
                if (fft_done) begin
                    w_state_next = S_START_UNLOAD;
                end else if (w_timer_expired) begin
                    w_state_next    = S_ERROR;
                    w_err_code_next = ERR_FFT_TIMEOUT;
                end
            end

            S_START_UNLOAD: begin
                unload_start = 1'b1;
                w_timer_next = '0;
                w_state_next = S_WAIT_UNLOAD;
            end

            S_WAIT_UNLOAD: begin
                w_timer_next = r_timer + 1'b1;
                // An error response poisons the frame even if done arrives too.
                if (unload_err) begin
                    w_state_next    = S_ERROR;
                    w_err_code_next = ERR_UNLOAD;
                end else if (unload_done) begin
                    w_frame_cnt_next  = r_frame_cnt + 8'd1;
                    w_sample_cnt_next = '0;
                    w_state_next      = enable ? S_CAPTURE : S_IDLE;
                end else if (w_timer_expired) begin
                    w_state_next    = S_ERROR;
                    w_err_code_next = ERR_UNLOAD_TMO;
                end
            end

            S_ERROR: begin
                if (clear_err) begin
                    w_state_next    = S_IDLE;
                    w_err_code_next = ERR_NONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Overrun is sticky; the acknowledge takes priority over a new drop.
    always_comb begin
        w_overrun_next = r_overrun;
        if (clear_err) begin
            w_overrun_next = 1'b0;
        end else if (sample_valid && enable && w_in_processing) begin
            w_overrun_next = 1'b1;
        end
    end

    assign cap_addr  = r_sample_cnt;
    assign busy      = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign frame_cnt = r_frame_cnt;
    assign err_code  = r_err_code;
    assign overrun   = r_overrun;

endmodule
